calc_core: RTL and testbench
============================

Name: calc_core

Overview:
- Arithmetic engine that sits directly downstream of the AXI4-Lite slave register file of the calculator IP.
- Consumes the register outputs as inputs: operand A (reg0), operand B (reg1) and control (reg2: opcode plus start bit).
- Produces the result and status words that the register file returns on reads of reg3 and the status register.
- Multi-cycle: single-cycle ops complete in 2 cycles; MUL and DIV are iterative, one bit per cycle.

Parameters:
DATA_WIDTH, 32, operand/result width; must be even and >= 4.
CNT_WIDTH, 6, iteration counter width; must satisfy 2**CNT_WIDTH > DATA_WIDTH.

Ports:
ACLK  input  1  single clock; all state updates on rising edge.
ARESET  input  1  synchronous, active-high reset.
op_a  input  DATA_WIDTH  operand A, unsigned.
op_b  input  DATA_WIDTH  operand B, unsigned.
opcode  input  3  0 ADD, 1 SUB, 2 MUL, 3 DIV, 4 AND, 5 OR, 6 XOR, 7 illegal.
start  input  1  request; sampled only in IDLE.
busy  output  1  high whenever state != IDLE.
done  output  1  one-cycle pulse; result and flags are valid from this cycle on.
result  output  DATA_WIDTH  sum / difference / product low / quotient / logic result.
result_hi  output  DATA_WIDTH  product high / remainder; 0 for all other ops.
carry  output  1  ADD carry-out; SUB borrow (op_a < op_b); 0 for all other ops.
div_by_zero  output  1  DIV with op_b == 0.
illegal_op  output  1  opcode 7.

Behaviour:
- Reset: on any edge with ARESET=1, state<=IDLE, counter<=0, and all outputs and internal operand registers <=0. Reset has priority over everything, including mid-iteration; an aborted operation produces no done.
- States: IDLE, EXEC, MUL_ITER, DIV_ITER, DONE.
- IDLE, edge k with start=1: latch op_a, op_b, opcode; clear counter.
  - opcode 2 -> MUL_ITER.
  - opcode 3 with op_b != 0 -> DIV_ITER.
  - All other opcodes, including DIV with op_b=0 and opcode 7 -> EXEC.
- start is ignored outside IDLE. Input changes after the latch edge have no effect.
- EXEC (one cycle): compute, write result, result_hi and all flags, go to DONE.
  - Single-cycle op: start at edge k -> done high in the cycle after edge k+1, sampled at edge k+2.
- MUL_ITER: shift-add unsigned multiply, one multiplier bit per cycle, DATA_WIDTH cycles.
  - On the final iteration edge, write the 2*DATA_WIDTH product: result = low half, result_hi = high half. Then go to DONE.
  - Latency: done sampled at edge k+DATA_WIDTH+1 (k+33 at the default width).
- DIV_ITER: restoring unsigned divide, one quotient bit per cycle, DATA_WIDTH cycles.
  - result = quotient, result_hi = remainder. Same latency as MUL.
- DONE: done=1 for exactly one cycle, then go to IDLE unconditionally.
  - A start asserted during the DONE cycle is ignored.
  - Back-to-back ops: start held high is accepted in the first IDLE cycle after DONE.
- Arithmetic rules:
  - ADD/SUB wrap modulo 2**DATA_WIDTH.
  - carry = bit DATA_WIDTH of the (DATA_WIDTH+1)-bit sum or difference.
- Divide by zero: result = all ones, result_hi = op_a, div_by_zero=1. Completes through EXEC with 2-cycle latency.
- Illegal opcode: result = 0, result_hi = 0, illegal_op=1. Completes through EXEC with 2-cycle latency.
- Flags: all flags are rewritten on every completion; flags not relevant to the op are cleared.
- Hold: result, result_hi and flags hold their values until the next completion or reset.
- busy: low in IDLE, high from the cycle after the latch edge through the DONE cycle inclusive.

Test Plan:
- ADD 0xFFFFFFFF + 0x00000002, start at edge k -> done sampled at k+2, result=0x00000001, carry=1, busy high for exactly 2 cycles.
- SUB 0x5 - 0x7 -> result=0xFFFFFFFE, carry=1. Then SUB 0x7 - 0x5 back-to-back with start held high -> result=0x2, carry=0.
- MUL 0xFFFFFFFF * 0xFFFFFFFF -> done sampled at k+33, result=0x00000001, result_hi=0xFFFFFFFE. Toggling op_a mid-iteration leaves the result unchanged.
- DIV 100 / 7 -> result=14, result_hi=2 at k+33. Then DIV 0x1234 / 0 -> result=0xFFFFFFFF, result_hi=0x1234, div_by_zero=1 at k+2.
- Opcode 7 -> illegal_op=1, result=0. The next AND 0xF0F0 & 0xFF00 -> result=0xF000 and illegal_op cleared.
- Reset mid-MUL, asserted at iteration 10 -> all outputs 0 on the next edge, no done pulse. A new ADD 3+4 after reset -> result=7.

Source files
------------

// File: rtl/calc_core.sv
// Multi-cycle arithmetic engine behind the calculator register file.
// Single-cycle ops go through EXEC; MUL and DIV iterate one bit per cycle.
module calc_core #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CNT_WIDTH  = 6
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    input  logic [DATA_WIDTH-1:0] op_a,
    input  logic [DATA_WIDTH-1:0] op_b,
    input  logic [2:0]            opcode,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] result,
    output logic [DATA_WIDTH-1:0] result_hi,
    output logic                  carry,
    output logic                  div_by_zero,
    output logic                  illegal_op
);

    localparam int unsigned W = DATA_WIDTH;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_MUL = 3'd2;
    localparam logic [2:0] OP_DIV = 3'd3;
    localparam logic [2:0] OP_AND = 3'd4;
    localparam logic [2:0] OP_OR  = 3'd5;
    localparam logic [2:0] OP_XOR = 3'd6;

    typedef enum logic [2:0] {
        S_IDLE,
        S_EXEC,
        S_MUL_ITER,
        S_DIV_ITER,
        S_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [W-1:0]         a_q, a_d;
    logic [W-1:0]         b_q, b_d;
    logic [W-1:0]         acc_q, acc_d;
    logic [2:0]           op_q, op_d;
    logic [W-1:0]         result_q, result_d;
    logic [W-1:0]         result_hi_q, result_hi_d;
    logic                 carry_q, carry_d;
    logic                 dbz_q, dbz_d;
    logic                 ill_q, ill_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    logic [W:0]           sum;
    logic [W:0]           diff;
    logic [W:0]           mul_sum;
    logic [W:0]           div_sh;
    logic                 div_ge;
    logic [W-1:0]         rem_n;
    logic                 last_iter;

    // acc_q holds the running product high half (MUL) or partial remainder (DIV)
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        a_d         = a_q;
        b_d         = b_q;
        acc_d       = acc_q;
        op_d        = op_q;
        result_d    = result_q;
        result_hi_d = result_hi_q;
        carry_d     = carry_q;
        dbz_d       = dbz_q;
        ill_d       = ill_q;

        sum       = {1'b0, a_q} + {1'b0, b_q};
        diff      = {1'b0, a_q} - {1'b0, b_q};
        mul_sum   = {1'b0, acc_q} + (b_q[0] ? {1'b0, a_q} : (W+1)'(0));
        div_sh    = {acc_q, a_q[W-1]};
        div_ge    = (div_sh >= {1'b0, b_q});
        rem_n     = div_ge ? W'(div_sh - {1'b0, b_q}) : W'(div_sh);
        last_iter = (cnt_q == CNT_WIDTH'(W - 1));

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d   = op_a;
                    b_d   = op_b;
                    op_d  = opcode;
                    cnt_d = '0;
                    acc_d = '0;
                    if (opcode == OP_MUL) begin
                        state_d = S_MUL_ITER;
                    end else if (opcode == OP_DIV && op_b != '0) begin
                        state_d = S_DIV_ITER;
                    end else begin
                        state_d = S_EXEC;
                    end
                end
            end
            S_EXEC: begin
                result_hi_d = '0;
                carry_d     = 1'b0;
                dbz_d       = 1'b0;
                ill_d       = 1'b0;
                case (op_q)
                    OP_ADD: begin
                        result_d = sum[W-1:0];
                        carry_d  = sum[W];
                    end
                    OP_SUB: begin
                        result_d = diff[W-1:0];
                        carry_d  = diff[W];
                    end
                    OP_DIV: begin
                        // only a zero divisor reaches EXEC
                        result_d    = '1;
                        result_hi_d = a_q;
                        dbz_d       = 1'b1;
                    end
                    OP_AND:  result_d = a_q & b_q;
                    OP_OR:   result_d = a_q | b_q;
                    OP_XOR:  result_d = a_q ^ b_q;
                    default: begin
                        result_d = '0;
                        ill_d    = 1'b1;
                    end
                endcase
                state_d = S_DONE;
            end
            S_MUL_ITER: begin
                acc_d = mul_sum[W:1];
                b_d   = {mul_sum[0], b_q[W-1:1]};
                cnt_d = cnt_q + CNT_WIDTH'(1);
                if (last_iter) begin
                    result_d    = {mul_sum[0], b_q[W-1:1]};
                    result_hi_d = mul_sum[W:1];
                    carry_d     = 1'b0;
                    dbz_d       = 1'b0;
                    ill_d       = 1'b0;
                    state_d     = S_DONE;
                end
            end
            S_DIV_ITER: begin
                acc_d = rem_n;
                a_d   = {a_q[W-2:0], div_ge};
                cnt_d = cnt_q + CNT_WIDTH'(1);
                if (last_iter) begin
                    result_d    = {a_q[W-2:0], div_ge};
                    result_hi_d = rem_n;
                    carry_d     = 1'b0;
                    dbz_d       = 1'b0;
                    ill_d       = 1'b0;
                    state_d     = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            acc_q       <= '0;
            op_q        <= '0;
            result_q    <= '0;
            result_hi_q <= '0;
            carry_q     <= 1'b0;
            dbz_q       <= 1'b0;
            ill_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            acc_q       <= acc_d;
            op_q        <= op_d;
            result_q    <= result_d;
            result_hi_q <= result_hi_d;
            carry_q     <= carry_d;
            dbz_q       <= dbz_d;
            ill_q       <= ill_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign result      = result_q;
    assign result_hi   = result_hi_q;
    assign carry       = carry_q;
    assign div_by_zero = dbz_q;
    assign illegal_op  = ill_q;

endmodule

// File: tb/tb_calc_core.sv
// Directed bench for calc_core: expected results queued at launch, popped on done.
module tb_calc_core;

    localparam int unsigned W = 32;

    logic         ACLK = 1'b0;
    logic         ARESET;
    logic [W-1:0] op_a, op_b;
    logic [2:0]   opcode;
    logic         start;
    logic         busy, done, carry, div_by_zero, illegal_op;
    logic [W-1:0] result, result_hi;

    calc_core #(.DATA_WIDTH(W), .CNT_WIDTH(6)) dut (
        .ACLK(ACLK), .ARESET(ARESET), .op_a(op_a), .op_b(op_b),
        .opcode(opcode), .start(start), .busy(busy), .done(done),
        .result(result), .result_hi(result_hi), .carry(carry),
        .div_by_zero(div_by_zero), .illegal_op(illegal_op)
    );

    always #5 ACLK = ~ACLK;

    typedef struct {
        logic [W-1:0] res;
        logic [W-1:0] hi;
        logic         c;
        logic         dz;
        logic         il;
        int           lat;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t         m;
        logic [W:0]   t;
        logic [2*W-1:0] p;
        m.res = '0; m.hi = '0; m.c = 1'b0; m.dz = 1'b0; m.il = 1'b0; m.lat = 2;
        case (op)
            3'd0: begin t = {1'b0, a} + {1'b0, b}; m.res = t[W-1:0]; m.c = t[W]; end
            3'd1: begin m.res = a - b; m.c = (a < b); end
            3'd2: begin
                p = (2*W)'(a) * (2*W)'(b);
                m.res = p[W-1:0]; m.hi = p[2*W-1:W]; m.lat = W + 1;
            end
            3'd3: begin
                if (b == '0) begin m.res = '1; m.hi = a; m.dz = 1'b1; end
                else begin m.res = a / b; m.hi = a % b; m.lat = W + 1; end
            end
            3'd4: m.res = a & b;
            3'd5: m.res = a | b;
            3'd6: m.res = a ^ b;
            default: m.il = 1'b1;
        endcase
        return m;
    endfunction

    // drive one request in IDLE; returns just after the latch edge
    task automatic launch(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input bit hold);
        @(negedge ACLK);
        op_a = a; op_b = b; opcode = op; start = 1'b1;
        exp_q.push_back(model(op, a, b));
        @(posedge ACLK);
        #1;
        if (!hold) start = 1'b0;
    endtask

    // cycle n after the latch edge is observed at the n-th following negedge
    task automatic wait_done(input string tag, input int toggle_at);
        exp_t e;
        int   cyc    = 0;
        int   busy_n = 0;
        bit   seen   = 1'b0;
        while (cyc < 200 && !seen) begin
            @(negedge ACLK);
            cyc++;
            if (cyc == toggle_at) op_a = ~op_a;
            if (busy) busy_n++;
            if (done) seen = 1'b1;
        end
        chk({tag, " done_seen"}, 64'(seen), 64'(1));
        chk({tag, " queue"}, 64'(exp_q.size() > 0), 64'(1));
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk({tag, " latency"}, 64'(cyc), 64'(e.lat));
            chk({tag, " busy_cycles"}, 64'(busy_n), 64'(e.lat));
            chk({tag, " result"}, 64'(result), 64'(e.res));
            chk({tag, " result_hi"}, 64'(result_hi), 64'(e.hi));
            chk({tag, " carry"}, 64'(carry), 64'(e.c));
            chk({tag, " div_by_zero"}, 64'(div_by_zero), 64'(e.dz));
            chk({tag, " illegal_op"}, 64'(illegal_op), 64'(e.il));
            @(negedge ACLK);
            chk({tag, " done_pulse"}, 64'(done), 64'(0));
            chk({tag, " busy_after"}, 64'(busy), 64'(0));
            chk({tag, " result_hold"}, 64'(result), 64'(e.res));
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " busy"}, 64'(busy), 64'(0));
        chk({tag, " done"}, 64'(done), 64'(0));
        chk({tag, " result"}, 64'(result), 64'(0));
        chk({tag, " result_hi"}, 64'(result_hi), 64'(0));
        chk({tag, " flags"}, 64'({carry, div_by_zero, illegal_op}), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int done_n;
        ARESET = 1'b1; start = 1'b0; op_a = '0; op_b = '0; opcode = '0;
        repeat (3) @(posedge ACLK);
        #1;
        chk_zero("reset");
        @(negedge ACLK);
        ARESET = 1'b0;

        launch(3'd0, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0);
        wait_done("add_wrap", 0);

        // back-to-back SUBs with start held; input changes after latch must not matter
        launch(3'd1, 32'h5, 32'h7, 1'b1);
        op_a = 32'h7; op_b = 32'h5;
        exp_q.push_back(model(3'd1, 32'h7, 32'h5));
        wait_done("sub_borrow", 0);
        @(posedge ACLK);
        #1;
        start = 1'b0;
        wait_done("sub_b2b", 0);

        launch(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        wait_done("mul_max", 10);

        launch(3'd3, 32'd100, 32'd7, 1'b0);
        wait_done("div_100_7", 0);
        launch(3'd3, 32'h1234, 32'h0, 1'b0);
        wait_done("div_zero", 0);

        for (int i = 0; i < 6; i++) begin
            launch(3'($urandom_range(0, 7)), $urandom, $urandom, 1'b0);
            wait_done("random_op", 0);
        end

        launch(3'd7, 32'h55, 32'h66, 1'b0);
        wait_done("illegal", 0);
        launch(3'd4, 32'hF0F0, 32'hFF00, 1'b0);
        wait_done("and_after_illegal", 0);

        // abort a MUL mid-iteration; no completion may follow
        launch(3'd2, 32'h1234, 32'h5678, 1'b0);
        void'(exp_q.pop_back());
        repeat (10) @(negedge ACLK);
        ARESET = 1'b1;
        @(posedge ACLK);
        #1;
        chk_zero("mid_mul_reset");
        @(negedge ACLK);
        ARESET = 1'b0;
        done_n = 0;
        repeat (40) begin
            @(negedge ACLK);
            if (done) done_n++;
        end
        chk("no_done_after_abort", 64'(done_n), 64'(0));
        chk("idle_after_abort", 64'(busy), 64'(0));

        launch(3'd0, 32'd3, 32'd4, 1'b0);
        wait_done("add_after_reset", 0);

        chk("scoreboard_empty", 64'(exp_q.size()), 64'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
